bsg_sdr_link_token_rx: RTL and testbench

Far-end receive endpoint for one SDR link lane: the block sitting opposite each per-tile SDR transmitter at the south edge of the manycore. It captures incoming `v`/`data` beats into a power-of-two buffer and hands them to a downstream valid/yumi consumer. It returns flow-control credits to the transmitter as a decimated toggling token line. It is single-clock; io-side instances and the testbench loopback model use it as the token-return counterpart of the transmitter's credit counter.

---
 rtl/bsg_sdr_link_pkg.sv | 11 +
 rtl/bsg_sdr_link_credit_to_token.sv | 20 ++
 rtl/bsg_sdr_link_token_rx.sv | 75 +++++++
 tb/tb_bsg_sdr_link_token_rx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bsg_sdr_link_pkg.sv
// bsg_sdr_link_pkg: shared types and helpers for the SDR link endpoints
// Contents: receiver status struct, transmitter initial-credit helper
package bsg_sdr_link_pkg;
   typedef struct packed {
      logic v;
      logic overflow;
   } bsg_sdr_link_token_rx_status_s;
   function automatic int tx_init_credits(int lg_fifo_depth);
      return 1 << lg_fifo_depth;
   endfunction
endpackage

// File: rtl/bsg_sdr_link_credit_to_token.sv
// bsg_sdr_link_credit_to_token: turns dequeue pulses into a decimated toggling token
// Ports: clk_i clock, reset_n_i async active-low reset, deq_i one credit per cycle high,
//        token_o counter MSB, toggles once per 2^lg_credit_to_token_decimation_p credits
module bsg_sdr_link_credit_to_token
#(
   parameter int lg_credit_to_token_decimation_p = 0
)
(
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic deq_i,
   output logic token_o
);
   localparam int cw_lp = lg_credit_to_token_decimation_p + 1;
   logic [cw_lp-1:0] cnt;
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) cnt <= '0;
      else if (deq_i) cnt <= cnt + cw_lp'(1);
   assign token_o = cnt[cw_lp-1];
endmodule

// File: rtl/bsg_sdr_link_token_rx.sv
// bsg_sdr_link_token_rx: SDR link lane receive buffer with decimated token credit return
// Build option: define BSG_SDR_LINK_RX_OVERFLOW_CHECK_EN for a sticky overflow flag
// Ports: core_clk_i clock, core_reset_n_i async active-low reset,
//        io_link_v_i/io_link_data_i incoming beats, io_link_token_o credit token line,
//        v_o/data_o/yumi_i buffer head handshake, overflow_o protocol-error flag
module bsg_sdr_link_token_rx
   import bsg_sdr_link_pkg::*;
#(
   parameter int width_p = 16,
   parameter int lg_fifo_depth_p = 3,
   parameter int lg_credit_to_token_decimation_p = 1
)
(
   input  logic               core_clk_i,
   input  logic               core_reset_n_i,
   input  logic               io_link_v_i,
   input  logic [width_p-1:0] io_link_data_i,
   output logic               io_link_token_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i,
   output logic               overflow_o
);
   localparam int aw_lp = lg_fifo_depth_p;
   localparam int pw_lp = lg_fifo_depth_p + 1;
   if (tx_init_credits(lg_fifo_depth_p) < 4) begin : g_bad_depth
      $error("lg_fifo_depth_p must be at least 2");
   end
   if (lg_credit_to_token_decimation_p > lg_fifo_depth_p - 1) begin : g_bad_dec
      $error("lg_credit_to_token_decimation_p must be <= lg_fifo_depth_p-1");
   end
   logic [pw_lp-1:0] wr_ptr, rd_ptr;
   logic [width_p-1:0] mem [tx_init_credits(lg_fifo_depth_p)];
   logic full, deq, enq;
   bsg_sdr_link_token_rx_status_s status;
   // extra pointer bit distinguishes full from empty when the low bits match
   assign full = (wr_ptr[aw_lp] != rd_ptr[aw_lp]) && (wr_ptr[aw_lp-1:0] == rd_ptr[aw_lp-1:0]);
   assign status.v = wr_ptr != rd_ptr;
   assign deq = status.v & yumi_i;
   // a same-cycle dequeue frees the slot the full-buffer write lands in
   assign enq = io_link_v_i & (~full | deq);
   always_ff @(posedge core_clk_i or negedge core_reset_n_i)
      if (!core_reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + pw_lp'(1);
         if (deq) rd_ptr <= rd_ptr + pw_lp'(1);
      end
   always_ff @(posedge core_clk_i)
      if (enq) mem[wr_ptr[aw_lp-1:0]] <= io_link_data_i;
   assign data_o = mem[rd_ptr[aw_lp-1:0]];
`ifdef BSG_SDR_LINK_RX_OVERFLOW_CHECK_EN
   logic overflow_r;
   always_ff @(posedge core_clk_i or negedge core_reset_n_i)
      if (!core_reset_n_i) overflow_r <= 1'b0;
      else if (io_link_v_i & ~enq) begin
         overflow_r <= 1'b1;
         $error("bsg_sdr_link_token_rx: overflow, beat dropped at wr_ptr=%0d", wr_ptr);
      end
   assign status.overflow = overflow_r;
`else
   assign status.overflow = 1'b0;
`endif
   assign v_o = status.v;
   assign overflow_o = status.overflow;
   bsg_sdr_link_credit_to_token #(
      .lg_credit_to_token_decimation_p(lg_credit_to_token_decimation_p)
   ) c2t (
      .clk_i    (core_clk_i),
      .reset_n_i(core_reset_n_i),
      .deq_i    (deq),
      .token_o  (io_link_token_o)
   );
endmodule

// File: tb/tb_bsg_sdr_link_token_rx.sv
// tb_bsg_sdr_link_token_rx: scoreboard bench for the SDR link receive endpoint
module tb_bsg_sdr_link_token_rx;
   localparam int W = 8;
   localparam int LG = 3;
   localparam int DEC = 1;
   localparam int D = 1 << LG;
   localparam int CPT = 1 << DEC;
`ifdef BSG_SDR_LINK_RX_OVERFLOW_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic io_link_v_i = 1'b0;
   logic [W-1:0] io_link_data_i = '0;
   logic io_link_token_o;
   logic v_o;
   logic [W-1:0] data_o;
   logic yumi_i = 1'b0;
   logic overflow_o;
   always #5 clk = ~clk;
   bsg_sdr_link_token_rx #(
      .width_p(W),
      .lg_fifo_depth_p(LG),
      .lg_credit_to_token_decimation_p(DEC)
   ) dut (
      .core_clk_i     (clk),
      .core_reset_n_i (rst_n),
      .io_link_v_i    (io_link_v_i),
      .io_link_data_i (io_link_data_i),
      .io_link_token_o(io_link_token_o),
      .v_o            (v_o),
      .data_o         (data_o),
      .yumi_i         (yumi_i),
      .overflow_o     (overflow_o)
   );
   int npass = 0;
   int ntot = 0;
   logic [W-1:0] sb [$];
   int occ = 0;
   int ndeq = 0;
   int credits = D;
   logic tok_last = 1'b0;
   logic exp_ovf = 1'b0;
   logic last_acc;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   // one cycle: check outputs against the model, then drive and advance the model
   task automatic step(input logic v, input logic [W-1:0] d, input logic y);
      logic deq, acc;
      @(negedge clk);
      if (io_link_token_o !== tok_last) credits += CPT;
      tok_last = io_link_token_o;
      chk("v_o", {31'b0, v_o}, {31'b0, occ > 0});
      chk("token", {31'b0, io_link_token_o}, (ndeq >> DEC) & 1);
      chk("overflow", {31'b0, overflow_o}, {31'b0, exp_ovf});
      io_link_v_i = v;
      io_link_data_i = d;
      yumi_i = y;
      deq = y && occ > 0;
      acc = v && (occ < D || deq);
      if (acc) sb.push_back(d);
      if (v && !acc && OVF_EN) exp_ovf = 1'b1;
      occ = occ + int'(acc) - int'(deq);
      ndeq += int'(deq);
      last_acc = acc;
   endtask
   // monitor: one pop per DUT dequeue, sampled just before the active edge
   initial forever begin
      @(negedge clk);
      #4;
      if (rst_n && v_o && yumi_i) begin
         if (sb.size() == 0) begin
            ntot++;
            $display("FAIL pop_empty: DUT dequeued %0h with nothing expected", data_o);
         end else chk("data_o", {24'b0, data_o}, {24'b0, sb.pop_front()});
      end
   end
   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_v", {31'b0, v_o}, 0);
      chk("rst_token", {31'b0, io_link_token_o}, 0);
      chk("rst_ovf", {31'b0, overflow_o}, 0);
      for (int i = 0; i < 4; i++) step(1'b1, W'(8'hA0 + i), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("drained_v", {31'b0, v_o}, 0);
      for (int i = 0; i < D; i++) step(1'b1, W'(8'hC0 + i), 1'b0);
      for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("token_end", {31'b0, io_link_token_o}, 0);
      for (int i = 0; i < D; i++) step(1'b1, W'(8'h80 + i), 1'b0);
      step(1'b1, 8'h77, 1'b1);
      chk("full_both_acc", {31'b0, last_acc}, 1);
      for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      for (int i = 0; i < D; i++) step(1'b1, W'(8'h60 + i), 1'b0);
      step(1'b1, 8'h55, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("overflow_flag", {31'b0, overflow_o}, {31'b0, OVF_EN});
      for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, W'(8'h31 + i), 1'b0);
      for (int i = 0; i < 2 && ((ndeq >> DEC) & 1) == 0; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("tok_before_rst", {31'b0, io_link_token_o}, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_v", {31'b0, v_o}, 0);
      chk("mid_rst_token", {31'b0, io_link_token_o}, 0);
      chk("mid_rst_ovf", {31'b0, overflow_o}, 0);
      sb.delete();
      occ = 0;
      ndeq = 0;
      exp_ovf = 1'b0;
      tok_last = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h12, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      credits = D - occ - (ndeq % CPT);
      for (int c = 0; c < 10000; c++) begin
         logic v;
         v = credits > 0 && $urandom_range(0, 1) == 1;
         if (v) credits--;
         step(v, W'($urandom), $urandom_range(0, 3) != 0);
         if (v) chk("rand_accept", {31'b0, last_acc}, 1);
      end
      for (int i = 0; i < 4 * D && occ > 0; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("drain_occ", occ, 0);
      chk("sb_empty", sb.size(), 0);
      chk("credits", credits, D - (ndeq % CPT));
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
